chunked_addsub: RTL
===================

Name: chunked_addsub

Overview:
- Multi-cycle, parametrised add/subtract unit for the ALU datapath.
- Processes operands in `chunk`-bit slices, LSB first, one slice per clock, with the carry rippling between cycles through a register.
- `carry_in` selects the operation: 0 computes x+y, 1 computes x-y (x + ~y + 1).
- Uses a start/busy/done handshake and produces registered result flags for the ALU control unit.

Parameters:
- `width`, default 9: operand and result width in bits.
- `chunk`, default 3: slice width per cycle. `width % chunk` must be 0, otherwise elaboration fails. N = `width`/`chunk` cycles per operation. `chunk` = `width` gives a single-cycle operation.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_b`  input  1  asynchronous active-low reset.
- `start`  input  1  request a new operation; sampled on the rising edge.
- `x`  input  `width`  operand A; captured when `start` is accepted.
- `y`  input  `width`  operand B; captured when `start` is accepted.
- `carry_in`  input  1  mode: 0 = add, 1 = subtract; captured when `start` is accepted.
- `sum`  output  `width`  result register.
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle pulse; result and flags are valid.
- `carry_out`  output  1  carry out of the MSB. In subtract mode, 1 = no borrow.
- `overflow`  output  1  two's-complement signed overflow.
- `zero`  output  1  `sum` == 0.
- `negative`  output  1  `sum`[`width`-1].

Behaviour:
- Reset (`rst_b` = 0, asynchronous, any state):
  - state = IDLE.
  - `sum`, `busy`, `done`, `carry_out`, `overflow`, `zero`, `negative` all 0.
  - Internal operand, working and carry registers cleared; slice index = 0.
  - Reset mid-operation aborts it; no `done` is produced.
- States: IDLE, RUN, DONE.
- IDLE, or DONE with `start` = 1 at edge E0:
  - Latch `x`, y' = `y` XOR {`width`{`carry_in`}}, carry register = `carry_in`, slice index = 0.
  - Go to RUN.
- DONE with `start` = 0: go to IDLE. Back-to-back operations therefore issue every N+1 cycles.
- RUN, at each edge E1..EN:
  - Working slice[i] = x[i] + y'[i] + carry; carry register = carry out of that slice; i++.
  - At EN, go to DONE and update outputs:
    - `sum` = working result.
    - `carry_out` = final carry.
    - `overflow` = (x msb == y' msb) && (`sum` msb != x msb).
    - `zero` and `negative` from the new `sum`.
- `busy` = 1 exactly in RUN, i.e. N cycles after E0. `done` = 1 exactly in DONE (one cycle); `busy` and `done` are never both high.
- `start` while in RUN is ignored; latched operands are unaffected. Input changes during RUN have no effect.
- `sum` and flags change only at EN and hold until the next completion. Partial results are never visible on `sum`.
- Arithmetic is modulo 2^`width`. Wrap-around is reported via `carry_out` and `overflow`, never saturated.
- Latency: `start` accepted at E0 -> `done` high in the cycle after EN (N cycles after E0).

Test Plan:
(`width`=9, `chunk`=3, N=3)
1. x=5, y=3, `carry_in`=0, `start` pulse:
   - `busy` high for 3 cycles, then `done` for 1 cycle.
   - `sum`=8, `carry_out`=0, `overflow`=0, `zero`=0, `negative`=0.
2. x=5, y=3, `carry_in`=1 -> `sum`=2, `carry_out`=1, `overflow`=0. Then x=3, y=3, `carry_in`=1 -> `sum`=0, `zero`=1, `carry_out`=1.
3. x=255, y=1, `carry_in`=0 -> `sum`=256 (9'h100), `overflow`=1, `negative`=1, `carry_out`=0. Then x=0, y=1, `carry_in`=1 -> `sum`=511 (9'h1FF), `carry_out`=0 (borrow), `negative`=1, `overflow`=0.
4. x=511, y=1, `carry_in`=0 -> `sum`=0, `carry_out`=1, `zero`=1, `overflow`=0.
5. During RUN of 5+3, pulse `start` with x=100, y=100 -> ignored; result `sum`=8. Then hold `start`=1 during the DONE cycle with x=7, y=2, `carry_in`=1 -> accepted; `done` 3 cycles later with `sum`=5.
6. Drop `rst_b` to 0 in the 2nd RUN cycle:
   - Outputs go to 0 immediately, asynchronously, with no `done`.
   - After release, x=10, y=20, `carry_in`=0 completes normally with `sum`=30.
   - Repeat case 1 with `chunk`=9 (N=1): `done` 1 cycle after `start`, `sum`=8.

Source files
------------

// File: rtl/chunked_addsub.sv
`default_nettype none
// ============================================================================
// Module      : chunked_addsub
// Description : Multi-cycle add/subtract unit. It processes CHUNK-bit slices
//               LSB first, and a register carries the ripple between cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_addsub #(
    parameter int WIDTH = 9,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             busy,
    output logic             done,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int c_N     = WIDTH / CHUNK;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_work;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;

    int                 w_base;
    logic [CHUNK-1:0]   w_x_slice;
    logic [CHUNK-1:0]   w_y_slice;
    logic [CHUNK:0]     w_slice;
    logic [WIDTH-1:0]   w_work_next;

    // r_y already holds the inverted operand in subtract mode, so every slice is a plain add.
    always_comb begin
        w_base      = int'(r_idx) * CHUNK;
        w_x_slice   = r_x[w_base +: CHUNK];
        w_y_slice   = r_y[w_base +: CHUNK];
        w_slice     = {1'b0, w_x_slice} + {1'b0, w_y_slice} + {{CHUNK{1'b0}}, r_carry};
        w_work_next = r_work;
        w_work_next[w_base +: CHUNK] = w_slice[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= c_ST_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_work    <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y ^ {WIDTH{carry_in}};
                        r_carry <= carry_in;
                        r_idx   <= '0;
                        r_work  <= '0;
                        r_state <= c_ST_RUN;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_slice[CHUNK];
                    if (r_idx == c_LAST_IDX) begin
                        r_state   <= c_ST_DONE;
                        sum       <= w_work_next;
                        carry_out <= w_slice[CHUNK];
                        overflow  <= (r_x[WIDTH-1] == r_y[WIDTH-1]) &&
                                     (w_work_next[WIDTH-1] != r_x[WIDTH-1]);
                        zero      <= (w_work_next == '0);
                        negative  <= w_work_next[WIDTH-1];
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == c_ST_RUN);
    assign done = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
